// File: rtl/bus_cmd_master_if.sv
// Bundle of the command stream, response stream and peripheral bus signals
// driven or observed by bus_cmd_master. The master modport is the view used
// by bus_cmd_master itself; the slave modport is the opposite side.
interface bus_cmd_master_if #(
    parameter int addrwidth_p   = 32,
    parameter int datawidth_p   = 32,
    parameter int errcntwidth_p = 8
);
    logic                     cmd_valid_i;
    logic                     cmd_accept_o;
    logic                     cmd_write_i;
    logic [addrwidth_p-1:0]   cmd_addr_i;
    logic [datawidth_p-1:0]   cmd_wdata_i;
    logic                     rsp_valid_o;
    logic                     rsp_accept_i;
    logic                     rsp_err_o;
    logic                     rsp_timeout_o;
    logic [datawidth_p-1:0]   rsp_rdata_o;
    logic [1:0]               bus_trans_o;
    logic [addrwidth_p-1:0]   bus_addr_o;
    logic                     bus_write_o;
    logic [datawidth_p-1:0]   bus_wdata_o;
    logic                     bus_ready_i;
    logic                     bus_resp_i;
    logic [datawidth_p-1:0]   bus_rdata_i;
    logic [errcntwidth_p-1:0] errcnt_o;
    logic                     busy_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_accept_i,
        input  bus_ready_i, bus_resp_i, bus_rdata_i,
        output cmd_accept_o,
        output rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o,
        output bus_trans_o, bus_addr_o, bus_write_o, bus_wdata_o,
        output errcnt_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output rsp_accept_i,
        output bus_ready_i, bus_resp_i, bus_rdata_i,
        input  cmd_accept_o,
        input  rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o,
        input  bus_trans_o, bus_addr_o, bus_write_o, bus_wdata_o,
        input  errcnt_o, busy_o
    );
endinterface

// File: rtl/bus_cmd_master.sv
// Upstream bus master: turns one command from the valid/accept command stream
// into a single non-pipelined bus transfer (address phase then data phase)
// and reports the outcome on the valid/accept response stream. Misaligned
// addresses are rejected without touching the bus, a data phase that runs
// too long is aborted, and failed responses are counted in a saturating
// error counter.
module bus_cmd_master #(
    parameter int addrwidth_p   = 32,
    parameter int datawidth_p   = 32,
    parameter int timeout_p     = 15,
    parameter int errcntwidth_p = 8
) (
    input  logic                 main_clk_i,
    input  logic                 main_rst_i,
    bus_cmd_master_if.master     mif
);
    // Counter is just wide enough to reach the limit; a zero limit still
    // needs a one-bit register so the logic stays well formed.
    localparam int tcnt_w = (timeout_p < 1) ? 1 : $clog2(timeout_p + 1);
    localparam logic [tcnt_w-1:0] tcnt_limit = tcnt_w'(timeout_p);

    localparam logic [1:0] trans_idle   = 2'b00;
    localparam logic [1:0] trans_nonseq = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RSP
    } state_t;

    state_t                   state;
    logic [tcnt_w-1:0]        tcnt;
    logic [datawidth_p-1:0]   cap_wdata;

    logic                     cmd_accept_q;
    logic                     rsp_valid_q;
    logic                     rsp_err_q;
    logic                     rsp_timeout_q;
    logic [datawidth_p-1:0]   rsp_rdata_q;
    logic [1:0]               bus_trans_q;
    logic [addrwidth_p-1:0]   bus_addr_q;
    logic                     bus_write_q;
    logic [datawidth_p-1:0]   bus_wdata_q;
    logic [errcntwidth_p-1:0] errcnt_q;

    assign mif.cmd_accept_o  = cmd_accept_q;
    assign mif.rsp_valid_o   = rsp_valid_q;
    assign mif.rsp_err_o     = rsp_err_q;
    assign mif.rsp_timeout_o = rsp_timeout_q;
    assign mif.rsp_rdata_o   = rsp_rdata_q;
    assign mif.bus_trans_o   = bus_trans_q;
    assign mif.bus_addr_o    = bus_addr_q;
    assign mif.bus_write_o   = bus_write_q;
    assign mif.bus_wdata_o   = bus_wdata_q;
    assign mif.errcnt_o      = errcnt_q;
    assign mif.busy_o        = (state != IDLE);

    // Transfer FSM with every output registered; the error counter rides
    // alongside and only moves on a response handshake that reports failure.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state         <= IDLE;
            tcnt          <= '0;
            cap_wdata     <= '0;
            cmd_accept_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            bus_trans_q   <= trans_idle;
            bus_addr_q    <= '0;
            bus_write_q   <= 1'b0;
            bus_wdata_q   <= '0;
            errcnt_q      <= '0;
        end else begin
            if (rsp_valid_q && mif.rsp_accept_i && rsp_err_q && (errcnt_q != '1)) begin
                errcnt_q <= errcnt_q + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_accept_q && mif.cmd_valid_i) begin
                        cmd_accept_q <= 1'b0;
                        cap_wdata    <= mif.cmd_wdata_i;
                        if (mif.cmd_addr_i[1:0] != 2'b00) begin
                            state         <= RSP;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_rdata_q   <= '0;
                        end else begin
                            state       <= ADDR;
                            bus_trans_q <= trans_nonseq;
                            bus_addr_q  <= mif.cmd_addr_i;
                            bus_write_q <= mif.cmd_write_i;
                        end
                    end else begin
                        cmd_accept_q <= 1'b1;
                    end
                end

                ADDR: begin
                    state       <= DATA;
                    bus_trans_q <= trans_idle;
                    bus_wdata_q <= bus_write_q ? cap_wdata : '0;
                    tcnt        <= tcnt_w'(1);
                end

                DATA: begin
                    if (mif.bus_ready_i) begin
                        state         <= RSP;
                        bus_wdata_q   <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= mif.bus_resp_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= (!bus_write_q && !mif.bus_resp_i) ? mif.bus_rdata_i : '0;
                    end else if ((timeout_p != 0) && (tcnt == tcnt_limit)) begin
                        state         <= RSP;
                        bus_wdata_q   <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                RSP: begin
                    if (mif.rsp_accept_i) begin
                        state         <= IDLE;
                        rsp_valid_q   <= 1'b0;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= '0;
                        cmd_accept_q  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed testbench for bus_cmd_master: each task drives one scenario and
// compares the observed outputs against hand-computed values.
module tb_bus_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_cmd_master_if #(.addrwidth_p(32), .datawidth_p(32), .errcntwidth_p(8)) bif ();

    bus_cmd_master #(
        .addrwidth_p(32), .datawidth_p(32), .timeout_p(15), .errcntwidth_p(8)
    ) dut (
        .main_clk_i(clk),
        .main_rst_i(rst),
        .mif(bif.master)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one clock edge.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bif.cmd_valid_i = 1'b1;
        bif.cmd_write_i = wr;
        bif.cmd_addr_i  = addr;
        bif.cmd_wdata_i = wdata;
        step();
        bif.cmd_valid_i = 1'b0;
    endtask

    // Consume the pending response with a one-cycle accept pulse.
    task automatic accept_rsp();
        bif.rsp_accept_i = 1'b1;
        step();
        bif.rsp_accept_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (bif.bus_trans_o !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_trans got %0h expected 0", bif.bus_trans_o); end
        n_checks++; if (bif.cmd_accept_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_accept got %0b expected 0", bif.cmd_accept_o); end
        n_checks++; if (bif.rsp_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got %0b expected 0", bif.rsp_valid_o); end
        n_checks++; if (bif.errcnt_o !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_errcnt got %0d expected 0", bif.errcnt_o); end
        n_checks++; if (bif.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %0b expected 0", bif.busy_o); end
        rst = 1'b0;
        step();
        n_checks++; if (bif.cmd_accept_o !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_accept got %0b expected 1", bif.cmd_accept_o); end
    endtask

    task automatic test_write();
        bif.bus_ready_i = 1'b1;
        bif.bus_resp_i  = 1'b0;
        do_cmd(1'b1, 32'h10, 32'hDEADBEEF);
        n_checks++; if (bif.bus_trans_o !== 2'd2) begin n_fail++; $display("[TB] FAIL wr_nonseq got %0h expected 2", bif.bus_trans_o); end
        n_checks++; if (bif.bus_addr_o !== 32'h10) begin n_fail++; $display("[TB] FAIL wr_addr got %0h expected 10", bif.bus_addr_o); end
        n_checks++; if (bif.bus_write_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_dir got %0b expected 1", bif.bus_write_o); end
        n_checks++; if (bif.cmd_accept_o !== 1'b0 || bif.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_accept_busy got %0b/%0b expected 0/1", bif.cmd_accept_o, bif.busy_o); end
        step();
        n_checks++; if (bif.bus_trans_o !== 2'd0) begin n_fail++; $display("[TB] FAIL wr_data_trans got %0h expected 0", bif.bus_trans_o); end
        n_checks++; if (bif.bus_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL wr_wdata got %0h expected deadbeef", bif.bus_wdata_o); end
        n_checks++; if (bif.rsp_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_rsp_early got %0b expected 0", bif.rsp_valid_o); end
        step();
        bif.bus_ready_i = 1'b0;
        n_checks++; if (bif.rsp_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_rsp_valid got %0b expected 1", bif.rsp_valid_o); end
        n_checks++; if ({bif.rsp_err_o, bif.rsp_timeout_o} !== 2'b00 || bif.rsp_rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL wr_rsp_fields got err=%0b to=%0b rdata=%0h expected 0/0/0", bif.rsp_err_o, bif.rsp_timeout_o, bif.rsp_rdata_o); end
        accept_rsp();
        n_checks++; if (bif.rsp_valid_o !== 1'b0 || bif.cmd_accept_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_done got valid=%0b accept=%0b expected 0/1", bif.rsp_valid_o, bif.cmd_accept_o); end
        n_checks++; if (bif.errcnt_o !== 8'd0) begin n_fail++; $display("[TB] FAIL wr_errcnt got %0d expected 0", bif.errcnt_o); end
    endtask

    task automatic test_read_wait();
        bif.bus_ready_i = 1'b0;
        do_cmd(1'b0, 32'h4, 32'hFFFFFFFF);
        step();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bif.bus_addr_o !== 32'h4 || bif.bus_write_o !== 1'b0 || bif.bus_wdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rd_wait_hold got addr=%0h wr=%0b wdata=%0h expected 4/0/0", bif.bus_addr_o, bif.bus_write_o, bif.bus_wdata_o); end
            n_checks++; if (bif.rsp_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_wait_rsp got %0b expected 0", bif.rsp_valid_o); end
            step();
        end
        bif.bus_ready_i = 1'b1;
        bif.bus_resp_i  = 1'b0;
        bif.bus_rdata_i = 32'h12345678;
        step();
        bif.bus_ready_i = 1'b0;
        bif.bus_rdata_i = 32'h0;
        n_checks++; if (bif.rsp_valid_o !== 1'b1 || bif.rsp_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_rsp got valid=%0b err=%0b expected 1/0", bif.rsp_valid_o, bif.rsp_err_o); end
        n_checks++; if (bif.rsp_rdata_o !== 32'h12345678) begin n_fail++; $display("[TB] FAIL rd_rdata got %0h expected 12345678", bif.rsp_rdata_o); end
        accept_rsp();
    endtask

    task automatic test_read_err();
        bif.bus_ready_i = 1'b1;
        bif.bus_resp_i  = 1'b1;
        bif.bus_rdata_i = 32'hAAAA5555;
        do_cmd(1'b0, 32'h8, 32'h0);
        step();
        step();
        bif.bus_ready_i = 1'b0;
        bif.bus_resp_i  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bif.rsp_valid_o !== 1'b1 || bif.rsp_err_o !== 1'b1 || bif.rsp_timeout_o !== 1'b0 || bif.rsp_rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL err_hold got valid=%0b err=%0b to=%0b rdata=%0h expected 1/1/0/0", bif.rsp_valid_o, bif.rsp_err_o, bif.rsp_timeout_o, bif.rsp_rdata_o); end
            n_checks++; if (bif.errcnt_o !== 8'd0 || bif.cmd_accept_o !== 1'b0) begin n_fail++; $display("[TB] FAIL err_hold_cnt got cnt=%0d accept=%0b expected 0/0", bif.errcnt_o, bif.cmd_accept_o); end
            step();
        end
        accept_rsp();
        n_checks++; if (bif.errcnt_o !== 8'd1) begin n_fail++; $display("[TB] FAIL err_count got %0d expected 1", bif.errcnt_o); end
    endtask

    task automatic test_misaligned();
        bif.rsp_accept_i = 1'b1;
        step();
        bif.rsp_accept_i = 1'b0;
        n_checks++; if (bif.errcnt_o !== 8'd1 || bif.cmd_accept_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stray_accept got cnt=%0d accept=%0b expected 1/1", bif.errcnt_o, bif.cmd_accept_o); end
        do_cmd(1'b1, 32'h13, 32'h55);
        n_checks++; if (bif.rsp_valid_o !== 1'b1 || bif.rsp_err_o !== 1'b1 || bif.rsp_timeout_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_rsp got valid=%0b err=%0b to=%0b expected 1/1/0", bif.rsp_valid_o, bif.rsp_err_o, bif.rsp_timeout_o); end
        n_checks++; if (bif.bus_trans_o !== 2'd0) begin n_fail++; $display("[TB] FAIL mis_trans got %0h expected 0", bif.bus_trans_o); end
        accept_rsp();
        n_checks++; if (bif.errcnt_o !== 8'd2 || bif.bus_trans_o !== 2'd0) begin n_fail++; $display("[TB] FAIL mis_done got cnt=%0d trans=%0h expected 2/0", bif.errcnt_o, bif.bus_trans_o); end
    endtask

    task automatic test_timeout();
        bif.bus_ready_i = 1'b0;
        do_cmd(1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 15; i++) step();
        n_checks++; if (bif.rsp_valid_o !== 1'b0 || bif.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL to_cycle15 got valid=%0b busy=%0b expected 0/1", bif.rsp_valid_o, bif.busy_o); end
        step();
        n_checks++; if (bif.rsp_valid_o !== 1'b1 || bif.rsp_err_o !== 1'b1 || bif.rsp_timeout_o !== 1'b1 || bif.rsp_rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL to_rsp got valid=%0b err=%0b to=%0b rdata=%0h expected 1/1/1/0", bif.rsp_valid_o, bif.rsp_err_o, bif.rsp_timeout_o, bif.rsp_rdata_o); end
        accept_rsp();
        n_checks++; if (bif.errcnt_o !== 8'd3) begin n_fail++; $display("[TB] FAIL to_errcnt got %0d expected 3", bif.errcnt_o); end

        do_cmd(1'b0, 32'h24, 32'h0);
        for (int i = 0; i < 15; i++) step();
        bif.bus_ready_i = 1'b1;
        bif.bus_resp_i  = 1'b0;
        bif.bus_rdata_i = 32'hCAFEF00D;
        step();
        bif.bus_ready_i = 1'b0;
        n_checks++; if (bif.rsp_valid_o !== 1'b1 || bif.rsp_err_o !== 1'b0 || bif.rsp_timeout_o !== 1'b0) begin n_fail++; $display("[TB] FAIL to_edge_rsp got valid=%0b err=%0b to=%0b expected 1/0/0", bif.rsp_valid_o, bif.rsp_err_o, bif.rsp_timeout_o); end
        n_checks++; if (bif.rsp_rdata_o !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL to_edge_rdata got %0h expected cafef00d", bif.rsp_rdata_o); end
        accept_rsp();
        n_checks++; if (bif.errcnt_o !== 8'd3) begin n_fail++; $display("[TB] FAIL to_edge_errcnt got %0d expected 3", bif.errcnt_o); end
    endtask

    task automatic test_back_to_back();
        int nonseq_seen;
        int rsp_seen;
        int overlap;
        nonseq_seen = 0;
        rsp_seen    = 0;
        overlap     = 0;
        bif.bus_ready_i  = 1'b1;
        bif.bus_resp_i   = 1'b0;
        bif.rsp_accept_i = 1'b1;
        bif.cmd_valid_i  = 1'b1;
        bif.cmd_write_i  = 1'b1;
        bif.cmd_addr_i   = 32'h30;
        bif.cmd_wdata_i  = 32'h1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (bif.bus_trans_o == 2'd2) begin
                nonseq_seen++;
                if (i != 1 && i != 5 && i != 9) overlap++;
            end
            if (bif.rsp_valid_o == 1'b1) begin
                rsp_seen++;
                if (i != 3 && i != 7 && i != 11) overlap++;
            end
            if (bif.rsp_valid_o == 1'b1 && bif.cmd_accept_o == 1'b1) overlap++;
        end
        bif.cmd_valid_i  = 1'b0;
        bif.rsp_accept_i = 1'b0;
        bif.bus_ready_i  = 1'b0;
        n_checks++; if (nonseq_seen !== 3) begin n_fail++; $display("[TB] FAIL b2b_nonseq got %0d expected 3", nonseq_seen); end
        n_checks++; if (rsp_seen !== 3) begin n_fail++; $display("[TB] FAIL b2b_rsp got %0d expected 3", rsp_seen); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("[TB] FAIL b2b_timing got %0d misplaced cycles expected 0", overlap); end
        n_checks++; if (bif.errcnt_o !== 8'd3 || bif.cmd_accept_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_end got cnt=%0d accept=%0b expected 3/1", bif.errcnt_o, bif.cmd_accept_o); end
    endtask

    task automatic test_reset_mid();
        bif.bus_ready_i = 1'b0;
        do_cmd(1'b1, 32'h40, 32'h77);
        step();
        step();
        rst = 1'b1;
        step();
        n_checks++; if (bif.bus_trans_o !== 2'd0 || bif.bus_addr_o !== 32'h0 || bif.bus_write_o !== 1'b0 || bif.bus_wdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_rst_bus got trans=%0h addr=%0h wr=%0b wdata=%0h expected all 0", bif.bus_trans_o, bif.bus_addr_o, bif.bus_write_o, bif.bus_wdata_o); end
        n_checks++; if (bif.cmd_accept_o !== 1'b0 || bif.rsp_valid_o !== 1'b0 || bif.rsp_err_o !== 1'b0 || bif.errcnt_o !== 8'd0 || bif.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_ctl got acc=%0b val=%0b err=%0b cnt=%0d busy=%0b expected all 0", bif.cmd_accept_o, bif.rsp_valid_o, bif.rsp_err_o, bif.errcnt_o, bif.busy_o); end
        rst = 1'b0;
        step();
        step();
        n_checks++; if (bif.rsp_valid_o !== 1'b0 || bif.cmd_accept_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_after got valid=%0b accept=%0b expected 0/1", bif.rsp_valid_o, bif.cmd_accept_o); end
    endtask

    task automatic test_saturation();
        int bad;
        int expected;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            do_cmd(1'b0, 32'(4 * i + 1), 32'h0);
            accept_rsp();
            expected = (i + 1 > 255) ? 255 : i + 1;
            if (bif.errcnt_o !== 8'(expected)) bad++;
            if (i == 253) begin
                n_checks++; if (bif.errcnt_o !== 8'd254) begin n_fail++; $display("[TB] FAIL sat_254 got %0d expected 254", bif.errcnt_o); end
            end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL sat_track got %0d wrong steps expected 0", bad); end
        n_checks++; if (bif.errcnt_o !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_final got %0d expected 255", bif.errcnt_o); end
    endtask

    initial begin
        bif.cmd_valid_i  = 1'b0;
        bif.cmd_write_i  = 1'b0;
        bif.cmd_addr_i   = 32'h0;
        bif.cmd_wdata_i  = 32'h0;
        bif.rsp_accept_i = 1'b0;
        bif.bus_ready_i  = 1'b0;
        bif.bus_resp_i   = 1'b0;
        bif.bus_rdata_i  = 32'h0;
        test_reset();
        test_write();
        test_read_wait();
        test_read_err();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
